// File: rtl/lods_12_rebuild.sv
// Rebuilds a 12-bit word from a frame of leading-one positions, counting distinct
// set bits and flagging protocol violations (illegal, misplaced-empty or out-of-order beats).
module lods_12_rebuild #(
  parameter int CHECK_ORDER = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_pos,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_word,
  output logic [3:0]  out_count,
  output logic        out_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] acc;
  logic [3:0]  cnt;
  logic        err;
  logic [3:0]  last_pos;
  logic        last_vld;

  logic        accept;
  logic        first_beat;
  logic        pos_legal;
  logic        pos_empty_ok;
  logic        order_bad;
  logic        beat_err;
  logic [11:0] bit_mask;
  logic        release_frame;

  assign in_ready      = (state != DONE);
  assign out_valid     = (state == DONE);
  assign accept        = in_valid && in_ready;
  assign first_beat    = (state == IDLE);
  assign release_frame = (state == DONE) && out_ready;

  // Outputs are forced to zero outside DONE so a consumer never sees a partial frame.
  assign out_word  = out_valid ? acc : 12'h000;
  assign out_count = out_valid ? cnt : 4'd0;
  assign out_err   = out_valid ? err : 1'b0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = in_last ? DONE : ACCUM;
      ACCUM:   if (accept && in_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pos_legal    = (in_pos <= 4'd11);
    pos_empty_ok = (in_pos == 4'hF) && first_beat && in_last;
    bit_mask     = 12'h000;
    if (pos_legal) bit_mask = 12'h001 << in_pos;
    // Order is judged only against a previously stored legal position.
    order_bad    = (CHECK_ORDER != 0) && pos_legal && !first_beat && last_vld &&
                   (in_pos >= last_pos);
    beat_err     = (!pos_legal && !pos_empty_ok) || order_bad;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || release_frame) begin
      acc      <= 12'h000;
      cnt      <= 4'd0;
      err      <= 1'b0;
      last_pos <= 4'd0;
      last_vld <= 1'b0;
    end else if (accept) begin
      if (pos_legal) begin
        acc      <= acc | bit_mask;
        last_pos <= in_pos;
        last_vld <= 1'b1;
        if ((acc & bit_mask) == 12'h000) cnt <= cnt + 4'd1;
      end
      if (beat_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lods_12_rebuild.sv
// Self-checking bench for lods_12_rebuild: directed frames plus random frames scored
// against a frame-level reference model; two instances cover both CHECK_ORDER settings.
module tb_lods_12_rebuild;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_pos;
  logic        in_last;
  logic        out_ready;

  logic        a_in_ready, b_in_ready;
  logic        a_out_valid, b_out_valid;
  logic [11:0] a_out_word, b_out_word;
  logic [3:0]  a_out_count, b_out_count;
  logic        a_out_err, b_out_err;

  int passed = 0;
  int total  = 0;

  logic [3:0] beats[$];

  always #5 clk = ~clk;

  lods_12_rebuild #(.CHECK_ORDER(1)) u_ord (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_pos(in_pos), .in_last(in_last), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_word(a_out_word), .out_count(a_out_count), .out_err(a_out_err)
  );

  lods_12_rebuild #(.CHECK_ORDER(0)) u_noord (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_pos(in_pos), .in_last(in_last), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_word(b_out_word), .out_count(b_out_count), .out_err(b_out_err)
  );

  task automatic chk(input string tag, input string what, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame-level reference: OR of legal positions, popcount, and the violation rules.
  task automatic model(input bit ord, output logic [11:0] w, output logic [3:0] c,
                       output bit e);
    int prev;
    bit have;
    w = 12'h000;
    e = 1'b0;
    have = 1'b0;
    prev = 0;
    for (int i = 0; i < beats.size(); i++) begin
      int p;
      p = int'(beats[i]);
      if (p <= 11) begin
        if (ord && have && p >= prev) e = 1'b1;
        w = w | (12'h001 << p);
        prev = p;
        have = 1'b1;
      end else if (p == 15) begin
        if (!(i == 0 && beats.size() == 1)) e = 1'b1;
      end else begin
        e = 1'b1;
      end
    end
    c = 4'($countones(w));
  endtask

  task automatic drive_beat(input string tag, input logic [3:0] p, input logic l);
    chk(tag, "in_ready_pre", 32'(a_in_ready), 32'd1);
    chk(tag, "out_valid_pre", 32'(a_out_valid), 32'd0);
    in_valid = 1'b1;
    in_pos   = p;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_pos   = 4'($urandom);
    in_last  = 1'($urandom);
  endtask

  task automatic check_out(input string tag, input logic [11:0] ew, input logic [3:0] ec,
                           input bit ea, input bit eb);
    chk(tag, "out_valid", 32'(a_out_valid), 32'd1);
    chk(tag, "out_valid_b", 32'(b_out_valid), 32'd1);
    chk(tag, "out_word", 32'(a_out_word), 32'(ew));
    chk(tag, "out_word_b", 32'(b_out_word), 32'(ew));
    chk(tag, "out_count", 32'(a_out_count), 32'(ec));
    chk(tag, "out_count_b", 32'(b_out_count), 32'(ec));
    chk(tag, "out_err", 32'(a_out_err), 32'(ea));
    chk(tag, "out_err_b", 32'(b_out_err), 32'(eb));
    chk(tag, "in_ready_done", 32'(a_in_ready), 32'd0);
  endtask

  task automatic run_frame(input string tag, input bit gaps, input int hold,
                           input bit use_model, input logic [11:0] ew_i,
                           input logic [3:0] ec_i, input bit ea_i, input bit eb_i);
    logic [11:0] ew, wb;
    logic [3:0]  ec, cb;
    bit          ea, eb;
    ew = ew_i; ec = ec_i; ea = ea_i; eb = eb_i;
    if (use_model) begin
      model(1'b1, ew, ec, ea);
      model(1'b0, wb, cb, eb);
    end
    for (int i = 0; i < beats.size(); i++) begin
      int g;
      g = gaps ? int'($urandom_range(0, 2)) : 0;
      repeat (g) tick();
      drive_beat(tag, beats[i], logic'(i == beats.size() - 1));
    end
    check_out(tag, ew, ec, ea, eb);
    for (int h = 0; h < hold; h++) begin
      tick();
      check_out({tag, "_hold"}, ew, ec, ea, eb);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk(tag, "out_valid_post", 32'(a_out_valid), 32'd0);
    chk(tag, "in_ready_post", 32'(a_in_ready), 32'd1);
    chk(tag, "out_word_post", 32'(a_out_word), 32'd0);
    chk(tag, "out_count_post", 32'(a_out_count), 32'd0);
    chk(tag, "out_err_post", 32'(a_out_err), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_pos    = 4'd5;
    in_last   = 1'b1;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("reset", "in_ready", 32'(a_in_ready), 32'd1);
    chk("reset", "out_valid", 32'(a_out_valid), 32'd0);
    chk("reset", "out_word", 32'(a_out_word), 32'd0);
    chk("reset", "out_count", 32'(a_out_count), 32'd0);
    chk("reset", "out_err", 32'(a_out_err), 32'd0);

    beats = '{4'd11, 4'd7, 4'd2};
    run_frame("desc", 1'b0, 0, 1'b0, 12'h884, 4'd3, 1'b0, 1'b0);

    beats = '{4'hF};
    run_frame("empty", 1'b0, 0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);

    beats = '{4'd3, 4'd5};
    run_frame("order", 1'b0, 0, 1'b0, 12'h028, 4'd2, 1'b1, 1'b0);

    beats = '{4'd4, 4'd13, 4'd4};
    run_frame("illegal", 1'b0, 0, 1'b0, 12'h010, 4'd1, 1'b1, 1'b1);

    beats = '{4'd11, 4'd7, 4'd2};
    run_frame("hold", 1'b0, 5, 1'b0, 12'h884, 4'd3, 1'b0, 1'b0);

    beats = '{4'd2, 4'hF};
    run_frame("late_empty", 1'b0, 0, 1'b0, 12'h004, 4'd1, 1'b1, 1'b1);

    // Reset mid-frame, with a beat presented during the reset cycle.
    drive_beat("rst_mid", 4'd9, 1'b0);
    drive_beat("rst_mid", 4'd6, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_pos   = 4'd3;
    in_last  = 1'b1;
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("rst_mid", "out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_mid", "in_ready", 32'(a_in_ready), 32'd1);
    tick();
    chk("rst_mid", "out_valid_later", 32'(a_out_valid), 32'd0);
    beats = '{4'd0};
    run_frame("after_rst", 1'b0, 0, 1'b0, 12'h001, 4'd1, 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      beats = {};
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) < 8) beats.push_back(4'($urandom_range(0, 11)));
        else beats.push_back(4'($urandom_range(12, 15)));
      end
      if ($urandom_range(0, 9) == 0) beats = '{4'hF};
      run_frame($sformatf("rand%0d", f), 1'b1, int'($urandom_range(0, 2)), 1'b1,
                12'h000, 4'd0, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule

// File: doc/lods_12_rebuild.md
LODS_12_REBUILD -- requirements
Module: lods_12_rebuild

Interface
REQ-001 The block SHALL have parameter CHECK_ORDER, default 1; 1 = flag any beat whose position is not strictly below the previous beat's position in the same frame.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, 1, beat present.
REQ-005 The block SHALL have port in_ready, output, 1, beat accepted when in_valid and in_ready are both 1.
REQ-006 The block SHALL have port in_pos, input, 4, bit position 0..11; 4'hF = "no leading one" marker; 12..14 are illegal.
REQ-007 The block SHALL have port in_last, input, 1, final beat of a frame.
REQ-008 The block SHALL have port out_valid, output, 1, result word available.
REQ-009 The block SHALL have port out_ready, input, 1, result consumed when out_valid and out_ready are both 1.
REQ-010 The block SHALL have port out_word, output, 12, rebuilt word.
REQ-011 The block SHALL have port out_count, output, 4, number of distinct bits set in out_word, 0..12.
REQ-012 The block SHALL have port out_err, output, 1, a protocol violation occurred in the frame.

Function
REQ-013 The block SHALL implement states IDLE (no beat yet), ACCUM (at least one beat accepted, no last yet) and DONE (result held).
REQ-014 in_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE; it is a registered function of state only and never depends on in_valid.
REQ-015 On an accepted beat with in_pos in 0..11, accumulator bit in_pos SHALL be set; count increments only if that bit was previously 0.
REQ-016 An accepted beat with in_pos in 12..14 SHALL set the error flag and leave word and count unchanged.
REQ-017 An accepted in_pos=4'hF beat SHALL be legal only as the first beat of a frame with in_last=1 (empty frame: word 0, count 0, err 0); in any other case it sets the error flag and leaves word and count unchanged.
REQ-018 With CHECK_ORDER=1, a non-first beat with in_pos in 0..11 and in_pos >= the last stored legal position SHALL set the error flag; the bit is still ORed in per REQ-015. With CHECK_ORDER=0 no order check is made.
REQ-019 The last legal position SHALL be updated only by beats with in_pos 0..11.
REQ-020 Transitions: IDLE->ACCUM on an accepted beat with in_last=0; IDLE or ACCUM->DONE on an accepted beat with in_last=1; ACCUM stays ACCUM on an accepted beat with in_last=0; DONE->IDLE on out_valid and out_ready both 1.
REQ-021 Latency: when the last beat is accepted in cycle N, out_valid SHALL be 1 in cycle N+1 with that beat's effect included.
REQ-022 out_word, out_count and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-023 On leaving DONE, the accumulator, count, error flag and last position SHALL clear, so in_ready=1 in the following cycle with a clean frame; the block has no bypass and no overlap between frames.
REQ-024 out_word, out_count and out_err SHALL read 0 whenever out_valid=0.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL go to IDLE with in_ready=1 after the edge, out_valid=0, out_word=0, out_count=0, out_err=0, and the accumulator and last position cleared.
REQ-026 A reset mid-frame (ACCUM) or in DONE SHALL discard the partial or held frame with no output produced; a beat presented in the reset cycle is not accepted.

Verification
REQ-027 The bench SHALL cover: beats 11,7,2 (last on 2) -> out_valid one cycle after the last beat, out_word=12'h884, out_count=3, out_err=0.
REQ-028 The bench SHALL cover: single beat 4'hF with last -> out_word=0, out_count=0, out_err=0.
REQ-029 The bench SHALL cover: beats 3,5 (last), CHECK_ORDER=1 -> out_word=12'h028, out_count=2, out_err=1; same stimulus with CHECK_ORDER=0 -> out_err=0.
REQ-030 The bench SHALL cover: beats 4,13,4 (last) -> out_word=12'h010, out_count=1, out_err=1 (illegal position and duplicate).
REQ-031 The bench SHALL cover: hold out_ready=0 for 5 cycles in DONE -> outputs stable and in_ready=0; release -> in_ready=1 the next cycle.
REQ-032 The bench SHALL cover: rst_n=0 after beats 9,6 -> no out_valid; a following frame with single beat 0 (last) -> out_word=12'h001, out_count=1, out_err=0.
